// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helper.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ERR1,
        ERR2
    } ahb_slv_state_e;

    // Little-endian byte enables for a 32-bit data bus.
    function automatic logic [3:0] size_to_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb3lite_sram_array.sv
// Word-organised SRAM: one byte-enabled write port, one asynchronous read port.
// Contents are never reset.
module ahb3lite_sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR.
// Optional macro AHB_SRAM_PROT_EN: user-mode accesses to the top quarter
// of memory are rejected with ERROR.
//
//   state | meaning
//   IDLE  | no data phase pending, ready/OKAY
//   DATA  | OKAY data phase, wait counter counting down to zero
//   ERR1  | first ERROR cycle, HREADYOUT low
//   ERR2  | second ERROR cycle, HREADYOUT high, next address may be taken
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int WORD_AW = $clog2(MEM_DEPTH);
    localparam int BYTE_AW = WORD_AW + 2;

    ahb_slv_state_e     state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BYTE_AW-1:0] addr_q, addr_d;
    logic               write_q, write_d;
    logic [2:0]         size_q, size_d;

    logic               accept;
    logic               range_err, size_err, align_err, prot_err, xfer_err;
    logic               take_addr;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;
    logic               unused_bits;

    assign accept = HSEL & HREADY & HTRANS[1];

    // The range check looks at the full HADDR so high bits never alias.
    assign range_err = 32'(HADDR) >= 32'(MEM_DEPTH * 4);
    assign size_err  = HSIZE > HSIZE_WORD;
    assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                       ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

`ifdef AHB_SRAM_PROT_EN
    assign prot_err = !HPROT[1] && (32'(HADDR) >= 32'(MEM_DEPTH * 3));
`else
    assign prot_err = 1'b0;
`endif

    assign xfer_err    = range_err | size_err | align_err | prot_err;
    assign unused_bits = ^{HTRANS[0], HBURST, HPROT};

    // State, wait counter and pending address-phase registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Next-state decode and bus response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        take_addr = 1'b0;
        mem_we    = 1'b0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;

        case (state_q)
            IDLE: begin
                take_addr = HREADY;
            end
            DATA: begin
                if (cnt_q != 4'd0) begin
                    HREADYOUT = 1'b0;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    take_addr = 1'b1;
                    mem_we    = write_q & ~HRESET;
                end
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ERR2;
            end
            ERR2: begin
                HRESP     = HRESP_ERROR;
                take_addr = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A completing phase either pipelines into the next transfer or idles.
        if (take_addr) begin
            if (accept) begin
                addr_d  = HADDR[BYTE_AW-1:0];
                write_d = HWRITE;
                size_d  = HSIZE;
                if (xfer_err) begin
                    state_d = ERR1;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = DATA;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end
    end

    ahb3lite_sram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (WORD_AW)
    ) u_array (
        .clk   (HCLK),
        .we    (mem_we),
        .be    (size_to_be(size_q, addr_q[1:0])),
        .waddr (addr_q[BYTE_AW-1:2]),
        .wdata (HWDATA),
        .raddr (addr_q[BYTE_AW-1:2]),
        .rdata (mem_rdata)
    );

    // Read data is only driven during an OKAY read data phase.
    always_comb begin
        HRDATA = '0;
        if (state_q == DATA && !write_q) begin
            HRDATA = mem_rdata;
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: three slaves on one bus (0, 2 and 3 wait states),
// each with HREADY looped back from its own HREADYOUT.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    logic        clk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [2:0]  hrdyo;
    logic [2:0]  hresp;
    logic [31:0] hrdata [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hrdyo[0]), .HREADYOUT(hrdyo[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb3lite_sram_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hrdyo[1]), .HREADYOUT(hrdyo[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    ahb3lite_sram_slave #(.ADDR_W(16), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(hrdyo[2]), .HREADYOUT(hrdyo[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated transfer on slave d. resp_seq = {any ERROR while stalled, final HRESP}.
    task automatic do_xfer(input int d, input logic wr, input logic [15:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic [1:0] resp_seq, output int waits);
        logic done;
        hsel       = '0;
        hsel[d]    = 1'b1;
        haddr      = a;
        htrans     = HTRANS_NONSEQ;
        hwrite     = wr;
        hsize      = sz;
        @(posedge clk); #1;
        hsel       = '0;
        htrans     = HTRANS_IDLE;
        hwdata     = wd;
        waits      = 0;
        resp_seq   = 2'b00;
        rd         = '0;
        done       = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (hrdyo[d]) begin
                rd          = hrdata[d];
                resp_seq[0] = hresp[d];
                done        = 1'b1;
            end else begin
                waits++;
                resp_seq[1] = resp_seq[1] | hresp[d];
            end
        end
        if (!done) chk("xfer_timeout", 32'(waits), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          w;

        hreset = 1'b1;
        hsel   = '0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hburst = 3'b000;
        hprot  = 4'b0011;
        hwdata = '0;
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        chk("rst_hreadyout", 32'(hrdyo), 32'h7);
        chk("rst_hresp",     32'(hresp), 32'h0);
        chk("rst_hrdata",    hrdata[0],  32'h0);
        @(posedge clk); #1;

        // zero wait states: word write then read
        do_xfer(0, 1'b1, 16'h0010, HSIZE_WORD, 32'hDEADBEEF, rd, rs, w);
        chk("ws0_wr_waits", 32'(w), 32'd0);
        chk("ws0_wr_resp",  32'(rs), 32'd0);
        do_xfer(0, 1'b0, 16'h0010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("ws0_rd_data",  rd, 32'hDEADBEEF);
        chk("ws0_rd_waits", 32'(w), 32'd0);
        chk("ws0_rd_resp",  32'(rs), 32'd0);

        // two wait states
        do_xfer(1, 1'b1, 16'h0020, HSIZE_WORD, 32'h12345678, rd, rs, w);
        chk("ws2_wr_waits", 32'(w), 32'd2);
        do_xfer(1, 1'b0, 16'h0020, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("ws2_rd_waits", 32'(w), 32'd2);
        chk("ws2_rd_data",  rd, 32'h12345678);

        // byte and halfword lanes
        do_xfer(0, 1'b1, 16'h0011, HSIZE_BYTE, 32'h0000AA00, rd, rs, w);
        do_xfer(0, 1'b0, 16'h0010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("byte_wr_data", rd, 32'hDEADAAEF);
        do_xfer(0, 1'b1, 16'h0012, HSIZE_HALF, 32'hBEEF0000, rd, rs, w);
        do_xfer(0, 1'b0, 16'h0010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("half_wr_data", rd, 32'hBEEFAAEF);
        do_xfer(0, 1'b1, 16'h0000, HSIZE_WORD, 32'h0BADF00D, rd, rs, w);

        // error responses
        do_xfer(0, 1'b1, 16'h1000, HSIZE_WORD, 32'h55555555, rd, rs, w);
        chk("err_range_waits", 32'(w), 32'd1);
        chk("err_range_resp",  32'(rs), 32'h3);
        do_xfer(0, 1'b1, 16'h0012, HSIZE_WORD, 32'h66666666, rd, rs, w);
        chk("err_align_waits", 32'(w), 32'd1);
        chk("err_align_resp",  32'(rs), 32'h3);
        do_xfer(0, 1'b1, 16'h0011, HSIZE_HALF, 32'h77777777, rd, rs, w);
        chk("err_half_align_resp", 32'(rs), 32'h3);
        do_xfer(0, 1'b1, 16'h0010, 3'b011, 32'h88888888, rd, rs, w);
        chk("err_size_resp",   32'(rs), 32'h3);
        do_xfer(0, 1'b0, 16'h1000, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("err_rd_resp",     32'(rs), 32'h3);
        chk("err_rd_data",     rd, 32'h0);
        do_xfer(0, 1'b0, 16'h0010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("err_mem_kept",    rd, 32'hBEEFAAEF);
        do_xfer(0, 1'b0, 16'h0000, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("err_no_alias",    rd, 32'h0BADF00D);
        do_xfer(0, 1'b0, 16'h0FFC, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("top_word_resp",   32'(rs), 32'h0);

        // pipelined write then read of the same word, no idle between
        hsel   = 3'b001;
        haddr  = 16'h0030;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        @(posedge clk); #1;
        hwrite = 1'b0;
        htrans = HTRANS_SEQ;
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("pipe_wr_ready", 32'(hrdyo[0]), 32'd1);
        @(posedge clk); #1;
        hsel   = '0;
        htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("pipe_rd_ready", 32'(hrdyo[0]), 32'd1);
        chk("pipe_rd_data",  hrdata[0], 32'hCAFEF00D);
        chk("pipe_rd_resp",  32'(hresp[0]), 32'd0);
        @(posedge clk); #1;

        // reset in the middle of a three-wait-state write
        do_xfer(2, 1'b1, 16'h0040, HSIZE_WORD, 32'h11112222, rd, rs, w);
        chk("ws3_wr_waits", 32'(w), 32'd3);
        hsel   = 3'b100;
        haddr  = 16'h0040;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        @(posedge clk); #1;
        hsel   = '0;
        htrans = HTRANS_IDLE;
        hwdata = 32'h99999999;
        @(negedge clk);
        chk("rst_mid_stalled", 32'(hrdyo[2]), 32'd0);
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(hrdyo[2]), 32'd1);
        chk("rst_mid_resp",  32'(hresp[2]), 32'd0);
        @(posedge clk); #1;
        do_xfer(2, 1'b0, 16'h0040, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("rst_mid_kept",  rd, 32'h11112222);
        chk("ws3_rd_waits",  32'(w), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
